// File: rtl/lockin_pkg.sv
// Shared constants, state encoding and saturation limits for the lock-in
// modulator and its sine LUT.
package lockin_pkg;

    localparam int PHASE_W = 24;
    localparam int LUT_AW  = 10;
    localparam int DATA_W  = 16;

    typedef enum logic [1:0] {
        MOD_OFF       = 2'd0,
        MOD_ACTIVE    = 2'd1,
        MOD_RAMP_DOWN = 2'd2
    } mod_state_e;

    localparam logic signed [DATA_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [DATA_W-1:0] SAT_MIN = 16'sh8000;

endpackage

// File: rtl/lockin_modulator_sine_quarter_lut.sv
// Quarter-wave sine ROM with quadrant folding; 2-cycle registered latency.
// The table carries one extra entry (the peak) so quadrants 1 and 3 fold cleanly.
module sine_quarter_lut #(
    parameter int LUT_AW = lockin_pkg::LUT_AW,
    parameter int DATA_W = lockin_pkg::DATA_W
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [LUT_AW+1:0]        addr_in,
    output logic signed [DATA_W-1:0] sine_out
);

    localparam int     MAG_W   = DATA_W - 1;
    localparam int     DEPTH   = (1 << LUT_AW) + 1;
    localparam longint ONE     = 64'sd1 << 30;
    localparam longint HALF_PI = 64'sd1686629713;
    localparam longint SCALE   = (64'sd1 << MAG_W) - 1;

    // Q30 Taylor series to x^17; accurate far below one LSB over [0, pi/2].
    function automatic logic [DEPTH*MAG_W-1:0] build_rom();
        logic [DEPTH*MAG_W-1:0] rom;
        longint x, x2, t, v;
        rom = '0;
        for (int i = 0; i < DEPTH; i++) begin
            x  = (longint'(i) * HALF_PI) >>> LUT_AW;
            x2 = (x * x) >>> 30;
            t  = ONE;
            for (int n = 8; n >= 1; n--)
                t = ONE - ((x2 * t) >>> 30) / longint'((2 * n) * (2 * n + 1));
            v = (((x * t) >>> 30) * SCALE + (ONE >>> 1)) >>> 30;
            if (v > SCALE)
                v = SCALE;
            rom[i*MAG_W +: MAG_W] = v[MAG_W-1:0];
        end
        return rom;
    endfunction

    localparam logic [DEPTH*MAG_W-1:0] ROM = build_rom();

    logic [1:0]        w_quad;
    logic [LUT_AW-1:0] w_idx;
    logic [LUT_AW:0]   w_rom_addr;
    logic [MAG_W-1:0]  r_mag;
    logic              r_neg;

    assign w_quad     = addr_in[LUT_AW+1:LUT_AW];
    assign w_idx      = addr_in[LUT_AW-1:0];
    assign w_rom_addr = w_quad[0] ? (LUT_AW+1)'(DEPTH - 1) - {1'b0, w_idx}
                                  : {1'b0, w_idx};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_mag    <= '0;
            r_neg    <= 1'b0;
            sine_out <= '0;
        end else begin
            r_mag    <= ROM[w_rom_addr*MAG_W +: MAG_W];
            r_neg    <= w_quad[1];
            sine_out <= r_neg ? -$signed({1'b0, r_mag}) : $signed({1'b0, r_mag});
        end
    end

endmodule

// File: rtl/lockin_modulator.sv
// Lock-in dither generator: phase accumulator, sine LUT, soft on/off amplitude
// slew, saturating add onto the servo output. LOCKIN_MOD_SAT_FLAG_EN adds a sticky clamp flag.
module lockin_modulator #(
    parameter int PHASE_W = lockin_pkg::PHASE_W,
    parameter int LUT_AW  = lockin_pkg::LUT_AW,
    parameter int DATA_W  = lockin_pkg::DATA_W
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               enable_in,
    input  logic [PHASE_W-1:0] pinc_in,
    input  logic [DATA_W-1:0]  amp_in,
    input  logic [DATA_W-1:0]  ramp_step_in,
    input  logic               sync_in,
    input  logic [DATA_W-1:0]  signal_in,
    output logic [DATA_W-1:0]  signal_out,
    output logic [PHASE_W-1:0] phase_out,
    output logic               active_out
`ifdef LOCKIN_MOD_SAT_FLAG_EN
    ,
    input  logic               sat_clr_in,
    output logic               sat_flag_out
`endif
);

    lockin_pkg::mod_state_e r_state, w_state_nxt;

    logic [DATA_W-1:0]        r_amp, w_amp_nxt;
    logic [PHASE_W-1:0]       r_phase, w_phase_nxt;
    logic signed [DATA_W-1:0] w_sine;
    logic signed [2*DATA_W:0] w_prod;
    logic signed [DATA_W-1:0] w_mod, r_mod, r_sig_d;
    logic signed [DATA_W:0]   w_sum;
    logic                     w_clamp;
    logic [DATA_W-1:0]        w_sat;

    // Move cur toward tgt by step, landing exactly on tgt; step 0 jumps.
    function automatic logic [DATA_W-1:0] slew(input logic [DATA_W-1:0] cur,
                                               input logic [DATA_W-1:0] tgt,
                                               input logic [DATA_W-1:0] step);
        logic [DATA_W:0]   diff;
        logic [DATA_W-1:0] res;
        if (cur < tgt) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            res  = (step == '0 || {1'b0, step} >= diff) ? tgt : cur + step;
        end else begin
            diff = {1'b0, cur} - {1'b0, tgt};
            res  = (step == '0 || {1'b0, step} >= diff) ? tgt : cur - step;
        end
        return res;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_amp_nxt   = r_amp;
        case (r_state)
            lockin_pkg::MOD_OFF: begin
                w_amp_nxt = '0;
                if (enable_in)
                    w_state_nxt = lockin_pkg::MOD_ACTIVE;
            end
            lockin_pkg::MOD_ACTIVE, lockin_pkg::MOD_RAMP_DOWN: begin
                w_amp_nxt = slew(r_amp, enable_in ? amp_in : '0, ramp_step_in);
                if (enable_in)
                    w_state_nxt = lockin_pkg::MOD_ACTIVE;
                else if (w_amp_nxt == '0)
                    w_state_nxt = lockin_pkg::MOD_OFF;
                else
                    w_state_nxt = lockin_pkg::MOD_RAMP_DOWN;
            end
            default: begin
                w_state_nxt = lockin_pkg::MOD_OFF;
                w_amp_nxt   = '0;
            end
        endcase
    end

    // Phase parks at 0 while OFF (and on the edge entering OFF) so bursts start at a zero crossing.
    assign w_phase_nxt = (sync_in || r_state == lockin_pkg::MOD_OFF ||
                          w_state_nxt == lockin_pkg::MOD_OFF) ? '0 : r_phase + pinc_in;

    sine_quarter_lut #(
        .LUT_AW (LUT_AW),
        .DATA_W (DATA_W)
    ) u_lut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .addr_in  (r_phase[PHASE_W-1 -: LUT_AW+2]),
        .sine_out (w_sine)
    );

    assign w_prod  = w_sine * $signed({1'b0, r_amp});
    assign w_mod   = DATA_W'(w_prod >>> DATA_W);
    assign w_sum   = (DATA_W+1)'(r_sig_d) + (DATA_W+1)'(r_mod);
    assign w_clamp = w_sum[DATA_W] ^ w_sum[DATA_W-1];
    assign w_sat   = w_clamp ? (w_sum[DATA_W] ? lockin_pkg::SAT_MIN : lockin_pkg::SAT_MAX)
                             : w_sum[DATA_W-1:0];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= lockin_pkg::MOD_OFF;
            r_amp      <= '0;
            r_phase    <= '0;
            r_sig_d    <= '0;
            r_mod      <= '0;
            signal_out <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_amp      <= w_amp_nxt;
            r_phase    <= w_phase_nxt;
            r_sig_d    <= signal_in;
            r_mod      <= w_mod;
            signal_out <= w_sat;
        end
    end

    assign phase_out  = r_phase;
    assign active_out = (r_state != lockin_pkg::MOD_OFF);

`ifdef LOCKIN_MOD_SAT_FLAG_EN
    logic r_sat_flag;

    // A clamp outranks a clear arriving in the same cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in)
            r_sat_flag <= 1'b0;
        else if (w_clamp)
            r_sat_flag <= 1'b1;
        else if (sat_clr_in)
            r_sat_flag <= 1'b0;
    end

    assign sat_flag_out = r_sat_flag;
`endif

endmodule
